// File: rtl/intc_pkg.sv
// Shared definitions for the vectored interrupt controller: FSM state codes,
// the replay NOP instruction and the vector-address helper.
package intc_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_SVC  = 2'd1;
    localparam state_t ST_RET  = 2'd2;

    localparam logic [15:0] NOP_IR = 16'h0800;

    // Vector slot address; the caller truncates the result to its PC width.
    function automatic logic [31:0] vec_addr(input logic [31:0] base,
                                             input logic [4:0]  idx,
                                             input int          shift);
        return base + (32'(idx) << shift);
    endfunction

endpackage

// File: rtl/intc_if.sv
// Fetch-side redirect bus between the interrupt controller (master) and the
// pipeline front end (slave).
interface intc_if #(
    parameter int PC_W = 16
);
    logic [PC_W-1:0] cur_pc;
    logic [PC_W-1:0] cur_ir;
    logic            accept;
    logic            eret_n;
    logic            redirect;
    logic [PC_W-1:0] redirect_pc;
    logic            ret_ir_vld;
    logic [PC_W-1:0] ret_ir;

    modport master (
        input  cur_pc, cur_ir, accept, eret_n,
        output redirect, redirect_pc, ret_ir_vld, ret_ir
    );

    modport slave (
        output cur_pc, cur_ir, accept, eret_n,
        input  redirect, redirect_pc, ret_ir_vld, ret_ir
    );
endinterface

// File: rtl/intc_prio_enc.sv
// Combinational priority encoder: index of the lowest set request bit.
module intc_prio_enc #(
    parameter int NUM_SRC = 8,
    parameter int IDX_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic [NUM_SRC-1:0] req,
    output logic [IDX_W-1:0]   idx,
    output logic               valid
);
    always_comb begin
        idx   = '0;
        valid = |req;
        // Scan downward so the lowest set bit is the last one written.
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (req[i]) idx = IDX_W'(i);
        end
    end
endmodule

// File: rtl/intc_vectored.sv
// Vectored interrupt controller: falling-edge pending latches, mask, global
// enable, lowest-index arbitration, PC/IR save and replay on eret.
// Optional macro INTC_SYNC_EN adds a 2-flop synchroniser on irq_n.
module intc_vectored
    import intc_pkg::*;
#(
    parameter int              NUM_SRC   = 8,
    parameter int              PC_W      = 16,
    parameter logic [PC_W-1:0] VEC_BASE  = 16'h0000,
    parameter int              VEC_SHIFT = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] irq_n,
    input  logic               ie_set,
    input  logic               ie_clr,
    input  logic               mask_we,
    input  logic [NUM_SRC-1:0] mask_wdata,
    intc_if.master             fbus,
    output logic               in_service,
    output logic [((NUM_SRC > 1) ? $clog2(NUM_SRC) : 1)-1:0] cause,
    output logic [NUM_SRC-1:0] pending
);
    localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    logic [NUM_SRC-1:0] irq_s, irq_hist_q, irq_hist_d, edge_det;
    logic [NUM_SRC-1:0] pending_q, pending_d, mask_q, mask_d, clr_vec;
    logic               ie_q, ie_d;
    state_t             state_q, state_d;
    logic               redirect_q, redirect_d, ret_ir_vld_q, ret_ir_vld_d;
    logic [PC_W-1:0]    redirect_pc_q, redirect_pc_d, ret_ir_q, ret_ir_d;
    logic [PC_W-1:0]    epc_q, epc_d, eir_q, eir_d;
    logic [IDX_W-1:0]   cause_q, cause_d, enc_idx;
    logic               enc_vld;

`ifdef INTC_SYNC_EN
    logic [NUM_SRC-1:0] sync1_q, sync1_d, sync2_q, sync2_d;
    assign sync1_d = irq_n;
    assign sync2_d = sync1_q;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= '1;
            sync2_q <= '1;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end
    assign irq_s = sync2_q;
`else
    assign irq_s = irq_n;
`endif

    assign irq_hist_d = irq_s;
    assign edge_det   = irq_hist_q & ~irq_s;

    intc_prio_enc #(.NUM_SRC(NUM_SRC), .IDX_W(IDX_W)) u_prio_enc (
        .req   (pending_q & mask_q),
        .idx   (enc_idx),
        .valid (enc_vld)
    );

    always_comb begin
        state_d       = state_q;
        clr_vec       = '0;
        redirect_d    = 1'b0;
        redirect_pc_d = redirect_pc_q;
        ret_ir_vld_d  = 1'b0;
        ret_ir_d      = PC_W'(NOP_IR);
        cause_d       = cause_q;
        epc_d         = epc_q;
        eir_d         = eir_q;
        ie_d          = ie_clr ? 1'b0 : (ie_set ? 1'b1 : ie_q);
        mask_d        = mask_we ? mask_wdata : mask_q;
        case (state_q)
            ST_IDLE: begin
                if (ie_q && enc_vld && fbus.accept) begin
                    redirect_d    = 1'b1;
                    redirect_pc_d = PC_W'(vec_addr(32'(VEC_BASE), 5'(enc_idx), VEC_SHIFT));
                    epc_d         = fbus.cur_pc;
                    eir_d         = fbus.cur_ir;
                    cause_d       = enc_idx;
                    clr_vec       = NUM_SRC'(1) << enc_idx;
                    state_d       = ST_SVC;
                end
            end
            ST_SVC: begin
                if (!fbus.eret_n) begin
                    redirect_d    = 1'b1;
                    redirect_pc_d = epc_q;
                    ret_ir_vld_d  = 1'b1;
                    ret_ir_d      = eir_q;
                    state_d       = ST_RET;
                end
            end
            // One-cycle guard so a return is never immediately re-interrupted.
            ST_RET:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        // A fresh edge on the source being taken keeps it pending.
        pending_d = (pending_q & ~clr_vec) | edge_det;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            irq_hist_q    <= '1;
            pending_q     <= '0;
            mask_q        <= '1;
            ie_q          <= 1'b0;
            redirect_q    <= 1'b0;
            redirect_pc_q <= '0;
            ret_ir_vld_q  <= 1'b0;
            ret_ir_q      <= PC_W'(NOP_IR);
            cause_q       <= '0;
        end else begin
            state_q       <= state_d;
            irq_hist_q    <= irq_hist_d;
            pending_q     <= pending_d;
            mask_q        <= mask_d;
            ie_q          <= ie_d;
            redirect_q    <= redirect_d;
            redirect_pc_q <= redirect_pc_d;
            ret_ir_vld_q  <= ret_ir_vld_d;
            ret_ir_q      <= ret_ir_d;
            cause_q       <= cause_d;
        end
    end

    // Saved context is only read in SVC, after a take has loaded it.
    always_ff @(posedge clk) begin
        epc_q <= epc_d;
        eir_q <= eir_d;
    end

    assign fbus.redirect    = redirect_q;
    assign fbus.redirect_pc = redirect_pc_q;
    assign fbus.ret_ir_vld  = ret_ir_vld_q;
    assign fbus.ret_ir      = ret_ir_q;
    assign in_service       = (state_q == ST_SVC);
    assign cause            = cause_q;
    assign pending          = pending_q;
endmodule

// File: tb/tb_intc_vectored.sv
// Directed bench for intc_vectored (default build, irq_n sampled directly).
module tb_intc_vectored;
    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] irq_n;
    logic       ie_set, ie_clr, mask_we;
    logic [7:0] mask_wdata;
    logic       in_service;
    logic [2:0] cause;
    logic [7:0] pending;
    int         checks = 0;
    int         errors = 0;
    int         redirect_cnt;

    intc_if #(.PC_W(16)) fbus ();

    intc_vectored #(.NUM_SRC(8), .PC_W(16), .VEC_BASE(16'h0000), .VEC_SHIFT(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .irq_n      (irq_n),
        .ie_set     (ie_set),
        .ie_clr     (ie_clr),
        .mask_we    (mask_we),
        .mask_wdata (mask_wdata),
        .fbus       (fbus),
        .in_service (in_service),
        .cause      (cause),
        .pending    (pending)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; irq_n = 8'hFF; ie_set = 1'b0; ie_clr = 1'b0;
        mask_we = 1'b0; mask_wdata = 8'h00;
        fbus.cur_pc = 16'h0000; fbus.cur_ir = 16'h0000;
        fbus.accept = 1'b1; fbus.eret_n = 1'b1;
        step(); step();
        chk("rst_redirect", 32'(fbus.redirect), 0);
        chk("rst_redirect_pc", 32'(fbus.redirect_pc), 0);
        chk("rst_ret_ir_vld", 32'(fbus.ret_ir_vld), 0);
        chk("rst_ret_ir", 32'(fbus.ret_ir), 32'h0800);
        chk("rst_in_service", 32'(in_service), 0);
        chk("rst_cause", 32'(cause), 0);
        chk("rst_pending", 32'(pending), 0);
        rst = 1'b1;
        step();

        // Enable with all lines idle: nothing may be taken.
        ie_set = 1'b1; step(); ie_set = 1'b0;
        redirect_cnt = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (fbus.redirect) redirect_cnt++;
        end
        chk("idle_no_redirect", 32'(redirect_cnt), 0);
        chk("idle_ret_ir", 32'(fbus.ret_ir), 32'h0800);

        // eret while idle is ignored.
        fbus.eret_n = 1'b0; step(); fbus.eret_n = 1'b1;
        chk("eret_idle_ignored", 32'(fbus.redirect), 0);

        // Single source 3 (mask still at reset value 8'hFF).
        irq_n = 8'hF7; fbus.cur_pc = 16'h0123; fbus.cur_ir = 16'h4A05;
        step();
        chk("src3_pending", 32'(pending), 32'h08);
        chk("src3_no_redirect_yet", 32'(fbus.redirect), 0);
        step();
        irq_n = 8'hFF;
        chk("src3_redirect", 32'(fbus.redirect), 1);
        chk("src3_vector", 32'(fbus.redirect_pc), 32'h000C);
        chk("src3_cause", 32'(cause), 3);
        chk("src3_in_service", 32'(in_service), 1);
        chk("src3_pending_clr", 32'(pending), 0);
        step();
        chk("src3_pulse_end", 32'(fbus.redirect), 0);
        chk("src3_still_svc", 32'(in_service), 1);

        // Return from source 3.
        fbus.eret_n = 1'b0; step(); fbus.eret_n = 1'b1;
        chk("ret3_redirect", 32'(fbus.redirect), 1);
        chk("ret3_pc", 32'(fbus.redirect_pc), 32'h0123);
        chk("ret3_ir_vld", 32'(fbus.ret_ir_vld), 1);
        chk("ret3_ir", 32'(fbus.ret_ir), 32'h4A05);
        chk("ret3_not_svc", 32'(in_service), 0);
        step();
        chk("ret3_idle_redirect", 32'(fbus.redirect), 0);
        chk("ret3_idle_vld", 32'(fbus.ret_ir_vld), 0);
        chk("ret3_idle_nop", 32'(fbus.ret_ir), 32'h0800);

        // Simultaneous edges on 5 and 2: 2 wins, 5 follows after the RET guard.
        irq_n = 8'hDB; fbus.cur_pc = 16'h0200; fbus.cur_ir = 16'h1111;
        step();
        chk("dual_pending", 32'(pending), 32'h24);
        step();
        irq_n = 8'hFF;
        chk("dual_first_redirect", 32'(fbus.redirect), 1);
        chk("dual_first_vector", 32'(fbus.redirect_pc), 32'h0008);
        chk("dual_first_cause", 32'(cause), 2);
        chk("dual_left_pending", 32'(pending), 32'h20);
        step();
        fbus.eret_n = 1'b0; step(); fbus.eret_n = 1'b1;
        chk("dual_ret_pc", 32'(fbus.redirect_pc), 32'h0200);
        chk("dual_ret_ir", 32'(fbus.ret_ir), 32'h1111);
        step();
        chk("dual_guard_no_take", 32'(fbus.redirect), 0);
        step();
        chk("dual_second_redirect", 32'(fbus.redirect), 1);
        chk("dual_second_vector", 32'(fbus.redirect_pc), 32'h0014);
        chk("dual_second_cause", 32'(cause), 5);
        fbus.eret_n = 1'b0; step(); fbus.eret_n = 1'b1;
        step(); step();
        chk("dual_back_idle", 32'(in_service), 0);

        // Masked source stays pending; unmasking with accept low holds the take.
        mask_we = 1'b1; mask_wdata = 8'hFB; step(); mask_we = 1'b0;
        irq_n = 8'hFB; fbus.cur_pc = 16'h0300;
        step();
        irq_n = 8'hFF;
        chk("mask_pending", 32'(pending), 32'h04);
        step(); step();
        chk("mask_no_take", 32'(fbus.redirect), 0);
        fbus.accept = 1'b0; mask_we = 1'b1; mask_wdata = 8'hFF;
        step(); mask_we = 1'b0;
        step(); step();
        chk("hold_no_take", 32'(fbus.redirect), 0);
        chk("hold_still_pending", 32'(pending), 32'h04);
        chk("hold_not_svc", 32'(in_service), 0);
        fbus.accept = 1'b1;
        step();
        chk("accept_redirect", 32'(fbus.redirect), 1);
        chk("accept_vector", 32'(fbus.redirect_pc), 32'h0008);
        chk("accept_cause", 32'(cause), 2);
        step();
        chk("accept_svc", 32'(in_service), 1);

        // Asynchronous reset in the middle of service.
        #2 rst = 1'b0;
        #1;
        chk("midrst_in_service", 32'(in_service), 0);
        chk("midrst_pending", 32'(pending), 0);
        chk("midrst_cause", 32'(cause), 0);
        chk("midrst_redirect_pc", 32'(fbus.redirect_pc), 0);
        chk("midrst_ret_ir", 32'(fbus.ret_ir), 32'h0800);
        step();
        rst = 1'b1;
        step();
        fbus.eret_n = 1'b0; step(); fbus.eret_n = 1'b1;
        chk("post_rst_eret_redirect", 32'(fbus.redirect), 0);
        chk("post_rst_eret_vld", 32'(fbus.ret_ir_vld), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
